// File: rtl/legv8_fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package legv8_fetch_pkg;
  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} fetch_state_t;

  localparam logic [OPC_W-1:0] HALT_OPCODE = 4'hF;

  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction
endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register; flush drops the valid bit but leaves the payload.
module fetch_out_reg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic         ready_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and fetch FSM: reads the ROM at pc and hands instructions to decode.
module instruction_fetch_unit #(
  parameter int                      ADDRESS_WIDTH     = 8,
  parameter int                      INSTRUCTION_WIDTH = 16,
  parameter int                      OPCODE_WIDTH      = 4,
  parameter int                      PC_INCREMENT_VAL  = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = 'h00,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE       = legv8_fetch_pkg::HALT_OPCODE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [ADDRESS_WIDTH-1:0]     imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
  input  logic                         redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]     redirect_target,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instr,
  output logic [ADDRESS_WIDTH-1:0]     out_pc,
  output logic                         halted
);
  import legv8_fetch_pkg::*;

  localparam int AW = ADDRESS_WIDTH;
  localparam int IW = INSTRUCTION_WIDTH;

  logic [AW-1:0]   pc_q, pc_d;
  fetch_state_t    state_q, state_d;
  logic            load;
  logic [IW+AW-1:0] out_data;

  assign imem_addr = pc_q;
  assign load      = (state_q == RUN) && !redirect_valid && (!out_valid || out_ready);

  // Redirect outranks everything, including a pending halt.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = {redirect_target[AW-1:1], 1'b0};
      state_d = RUN;
    end else if (load) begin
      pc_d = pc_q + AW'(PC_INCREMENT_VAL);
      if (instr_opcode(imem_instruction) == HALT_OPCODE)
        state_d = HALTED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_out_reg #(.W(IW + AW)) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .load_i  (load),
    .ready_i (out_ready),
    .data_i  ({imem_instruction, pc_q}),
    .valid_o (out_valid),
    .data_o  (out_data)
  );

  assign out_instr = out_data[IW+AW-1:AW];
  assign out_pc    = out_data[AW-1:0];
  assign halted    = (state_q == HALTED);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scenarios plus randomized ready/redirect traffic against a transfer-level model.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_instruction;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_target = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        halted;

  logic [7:0]  rom [256];
  int          total = 0;
  int          bad   = 0;
  bit          done  = 1'b0;

  // Reference model: current PC, the presented instruction and the halt flag.
  logic [7:0]  m_pc    = 8'h00;
  logic        m_valid = 1'b0;
  logic [15:0] m_instr = 16'h0000;
  logic [7:0]  m_opc   = 8'h00;
  logic        m_halt  = 1'b0;
  logic        m_ld;
  logic [15:0] m_word;

  instruction_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  assign imem_instruction = {rom[imem_addr], rom[imem_addr + 8'd1]};

  assign m_word = {rom[m_pc], rom[m_pc + 8'd1]};
  assign m_ld   = !m_halt && !redirect_valid && (!m_valid || out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 8'h00; m_valid <= 1'b0; m_instr <= 16'h0; m_opc <= 8'h00; m_halt <= 1'b0;
    end else if (redirect_valid) begin
      m_pc <= redirect_target & 8'hFE; m_valid <= 1'b0; m_halt <= 1'b0;
    end else if (m_ld) begin
      m_instr <= m_word; m_opc <= m_pc; m_valid <= 1'b1;
      m_pc    <= m_pc + 8'd2;
      if (m_word[15:12] == 4'hF) m_halt <= 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      chk("model imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("model out_valid", 32'(out_valid), 32'(m_valid));
      chk("model halted", 32'(halted), 32'(m_halt));
      if (m_valid) begin
        chk("model out_instr", 32'(out_instr), 32'(m_instr));
        chk("model out_pc", 32'(out_pc), 32'(m_opc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string nm, input logic [15:0] ins, input logic [7:0] pc,
                            input logic [7:0] nxt);
    chk({nm, " valid"}, 32'(out_valid), 32'd1);
    chk({nm, " instr"}, 32'(out_instr), 32'(ins));
    chk({nm, " pc"}, 32'(out_pc), 32'(pc));
    chk({nm, " imem_addr"}, 32'(imem_addr), 32'(nxt));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h00] = 8'h12; rom[8'h01] = 8'h34; rom[8'h02] = 8'h56; rom[8'h03] = 8'h78;
    rom[8'h04] = 8'hF0; rom[8'h05] = 8'h00;
    rom[8'h40] = 8'hAB; rom[8'h41] = 8'hCD;
    rom[8'hFE] = 8'h11; rom[8'hFF] = 8'h22;

    #12;
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset imem_addr", 32'(imem_addr), 32'h00);
    chk("reset halted", 32'(halted), 32'd0);
    chk("reset instr", 32'(out_instr), 32'h0);
    chk("reset pc", 32'(out_pc), 32'h0);

    step(); rst_n = 1'b1;
    step(); expect_out("stream0", 16'h1234, 8'h00, 8'h02);
    step(); expect_out("stream1", 16'h5678, 8'h02, 8'h04);

    out_ready = 1'b0;
    repeat (3) begin step(); expect_out("stall", 16'h5678, 8'h02, 8'h04); end
    out_ready = 1'b1;
    step(); expect_out("halt instr", 16'hF000, 8'h04, 8'h06);
    chk("halt flag", 32'(halted), 32'd1);
    repeat (2) begin
      step();
      chk("halted valid", 32'(out_valid), 32'd0);
      chk("halted imem_addr", 32'(imem_addr), 32'h06);
      chk("halted flag", 32'(halted), 32'd1);
    end

    redirect_valid = 1'b1; redirect_target = 8'h00;
    step();
    chk("resume halted", 32'(halted), 32'd0);
    chk("resume valid", 32'(out_valid), 32'd0);
    chk("resume imem_addr", 32'(imem_addr), 32'h00);
    redirect_valid = 1'b0; out_ready = 1'b0;
    step(); expect_out("resume", 16'h1234, 8'h00, 8'h02);

    redirect_valid = 1'b1; redirect_target = 8'h41;
    step();
    chk("redirect flush", 32'(out_valid), 32'd0);
    chk("redirect imem_addr", 32'(imem_addr), 32'h40);
    redirect_valid = 1'b0; out_ready = 1'b1;
    step(); expect_out("redirect target", 16'hABCD, 8'h40, 8'h42);

    redirect_valid = 1'b1; redirect_target = 8'hFE;
    step();
    chk("wrap imem_addr", 32'(imem_addr), 32'hFE);
    redirect_valid = 1'b0;
    step(); expect_out("wrap FE", 16'h1122, 8'hFE, 8'h00);
    step(); expect_out("wrap 00", 16'h1234, 8'h00, 8'h02);

    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async valid", 32'(out_valid), 32'd0);
    chk("async imem_addr", 32'(imem_addr), 32'h00);
    chk("async halted", 32'(halted), 32'd0);
    step(); rst_n = 1'b1;
    step(); expect_out("restart", 16'h1234, 8'h00, 8'h02);

    for (int c = 0; c < 3000; c++) begin
      out_ready       = ($urandom_range(3) != 0);
      redirect_valid  = ($urandom_range(9) == 0);
      redirect_target = 8'($urandom);
      step();
    end
    redirect_valid = 1'b0;
    step();
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
